// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver of one serial link.
//   OVS          : baud ticks per serial bit (16x oversampling)
//   uart_state_e : frame-sequencer states.
//                  PARITY is only reached when the parity bit is enabled.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int OVS = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// UART serial transmitter.
// A byte accepted from the host is sent on the tx pin as one frame:
//   - a start bit,
//   - DBIT data bits, LSB first,
//   - an optional parity bit,
//   - the stop period.
// Every bit lasts OVS (16) baud ticks. The stop period lasts SB_TICK ticks.
//
// Optional feature (compile-time macro):
//   UART_TX_PARITY_EN : when defined, a parity bit follows the data bits.
//                       The parity bit is computed when the byte is accepted.
//                       Its value is ^din[DBIT-1:0] ^ PARITY_ODD.
//
// Parameters:
//   DBIT       : data bits per frame (5..8). Upper bits of din are ignored.
//   SB_TICK    : baud ticks in the stop period (16/24/32).
//   PARITY_ODD : 1 = odd parity, 0 = even parity.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   s_tick       in   one-clk pulse at 16x the baud rate
//   tx_start     in   request to send din; honoured only while idle
//   din[7:0]     in   byte to transmit
//   tx_busy      out  high while a frame is in progress
//   tx_done_tick out  one-clk pulse in the last cycle of the stop period
//   tx           out  registered serial line, idles high
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx
);

    localparam logic [4:0] LAST_TICK      = 5'(OVS - 1);
    localparam logic [4:0] STOP_LAST_TICK = 5'(SB_TICK - 1);
    localparam logic [2:0] LAST_BIT       = 3'(DBIT - 1);

    // Reject parameter values the 5-bit tick and 3-bit bit counters cannot represent.
    if (DBIT < 5 || DBIT > 8 || SB_TICK < 1 || SB_TICK > 32 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_tx: parameter out of range");
    end

    uart_state_e state_q, state_d;
    logic [4:0]  tickCnt_q, tickCnt_d;
    logic [2:0]  bitCnt_q, bitCnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    localparam logic [7:0] DATA_MASK = 8'((1 << DBIT) - 1);
    logic        parity_q, parity_d;
`endif

    // State register.
    // On reset the line returns high immediately, so a partial frame
    // on the wire is simply cut off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tickCnt_q <= '0;
            bitCnt_q  <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tickCnt_q <= tickCnt_d;
            bitCnt_q  <= bitCnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Frame sequencer.
    // Everything holds between baud ticks; only acceptance in IDLE ignores s_tick.
    // The done pulse is decoded from registered state plus the tick, so it is clean.
    always_comb begin
        state_d      = state_q;
        tickCnt_d    = tickCnt_q;
        bitCnt_d     = bitCnt_q;
        shift_d      = shift_q;
        tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d     = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    shift_d   = din;
                    tickCnt_d = '0;
                    state_d   = START;
`ifdef UART_TX_PARITY_EN
                    parity_d  = (^(din & DATA_MASK)) ^ 1'(PARITY_ODD);
`endif
                end
            end
            START: begin
                if (s_tick) begin
                    if (tickCnt_q == LAST_TICK) begin
                        tickCnt_d = '0;
                        bitCnt_d  = '0;
                        state_d   = DATA;
                    end else begin
                        tickCnt_d = tickCnt_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tickCnt_q == LAST_TICK) begin
                        tickCnt_d = '0;
                        shift_d   = shift_q >> 1;
                        if (bitCnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bitCnt_d = bitCnt_q + 3'd1;
                        end
                    end else begin
                        tickCnt_d = tickCnt_q + 5'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (tickCnt_q == LAST_TICK) begin
                        tickCnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        tickCnt_d = tickCnt_q + 5'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (tickCnt_q == STOP_LAST_TICK) begin
                        tx_done_tick = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        tickCnt_d = tickCnt_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level is decoded from the state being entered.
    // The registered tx therefore changes on the same edge as the state,
    // and falls on the edge that accepts tx_start.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    assign tx_busy = (state_q != IDLE);
    assign tx      = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx.
// s_tick pulses every 4 clocks, so one serial bit lasts 64 clocks.
//
// A frame-level model runs alongside the DUT:
//   - each accepted byte becomes a list of line levels, each with a tick duration;
//   - the model steps through that list on baud ticks;
//   - tx, tx_busy and tx_done_tick are compared on every falling clock edge.
// Literal frame patterns and timing bounds pin the model itself.
//
// Build with +define+UART_TX_PARITY_EN to exercise the parity variant.
// That variant runs with SB_TICK = 32.
// ---------------------------------------------------------------------------
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int SB       = 32;
    localparam int PAR_BITS = 1;
`else
    localparam int SB       = 16;
    localparam int PAR_BITS = 0;
`endif
    localparam int PODD        = 0;
    localparam int FRAME_TICKS = 16 * (1 + 8 + PAR_BITS) + SB;
    localparam int NB          = 1 + 8 + PAR_BITS + 1;

    logic       clk;
    logic       reset;
    logic       s_tick;
    logic       tx_start;
    logic [7:0] din;
    logic       tx_busy;
    logic       tx_done_tick;
    logic       tx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int eCyc  = 0;
    int doneCount   = 0;
    int lastDoneCyc = 0;

    // Frame model: line levels of the current frame and the ticks each level lasts.
    logic mBits [0:11];
    int   mDur  [0:11];
    int   nBits    = 0;
    int   mIdx     = 0;
    int   mTickCnt = 0;
    bit   mActive  = 0;

    uart_tx #(
        .DBIT       (8),
        .SB_TICK    (SB),
        .PARITY_ODD (PODD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .tx_start     (tx_start),
        .din          (din),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick),
        .tx           (tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter and the baud tick: one pulse every fourth clock, changed just after the edge.
    initial begin
        int ph;
        ph     = 0;
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            ph     = (ph + 1) % 4;
            s_tick = (ph == 0);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model update on each rising edge.
    // Inputs only change 1ns after an edge or on the falling edge, so they are stable here.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                mActive = 0;
            end else if (!mActive) begin
                if (tx_start) begin
                    mBits[0] = 1'b0;
                    mDur[0]  = 16;
                    for (int i = 0; i < 8; i++) begin
                        mBits[1 + i] = din[i];
                        mDur[1 + i]  = 16;
                    end
                    nBits = 9;
                    if (PAR_BITS == 1) begin
                        mBits[nBits] = (^din) ^ 1'(PODD);
                        mDur[nBits]  = 16;
                        nBits++;
                    end
                    mBits[nBits] = 1'b1;
                    mDur[nBits]  = SB;
                    nBits++;
                    mIdx     = 0;
                    mTickCnt = 0;
                    mActive  = 1;
                end
            end else if (s_tick) begin
                mTickCnt++;
                if (mTickCnt == mDur[mIdx]) begin
                    mTickCnt = 0;
                    mIdx++;
                    if (mIdx == nBits) mActive = 0;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        logic eTx, eBusy, eDone;
        forever begin
            @(negedge clk);
            if (reset) begin
                eTx   = 1'b1;
                eBusy = 1'b0;
                eDone = 1'b0;
            end else begin
                eTx   = mActive ? mBits[mIdx] : 1'b1;
                eBusy = mActive;
                eDone = mActive && (mIdx == nBits - 1) && s_tick && (mTickCnt == mDur[mIdx] - 1);
            end
            checkOutput("tx", 32'(tx), 32'(eTx));
            checkOutput("busy", 32'(tx_busy), 32'(eBusy));
            checkOutput("done", 32'(tx_done_tick), 32'(eDone));
            if (tx_done_tick) begin
                doneCount++;
                lastDoneCyc = cyc;
            end
        end
    end

    // Wait, with a bound, until the transmitter is idle.
    task automatic waitIdle();
        int w;
        w = 0;
        while (tx_busy && w < 3000) begin
            @(negedge clk);
            w++;
        end
        checkOutput("idleTimeout", 32'(w < 3000), 32'd1);
    endtask

    // Pulse tx_start for one clock with byte d.
    // Afterwards eCyc holds the cycle number of the accepting edge.
    task automatic applyStimulus(input logic [7:0] d);
        @(posedge clk);
        #1;
        din      = d;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        eCyc     = cyc;
    endtask

    // Send d and check the line level in the middle of every bit against a literal pattern.
    // Bit k of expBits is the k-th level on the line.
    // With disturb set, din changes and an extra tx_start pulse arrives mid-frame.
    task automatic pinFrame(input logic [7:0] d, input logic [11:0] expBits, input bit disturb);
        int startDone, t, off;
        waitIdle();
        startDone = doneCount;
        applyStimulus(d);
        for (int k = 0; k < NB; k++) begin
            t = 32 + 64 * k;
            repeat (t - (cyc - eCyc)) @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("bit%0d", k), 32'(tx), 32'(expBits[k]));
            if (disturb && k == 3) begin
                din      = ~d;
                tx_start = 1'b1;
                @(posedge clk);
                #1;
                tx_start = 1'b0;
            end
        end
        waitIdle();
        checkOutput("donePulses", 32'(doneCount - startDone), 32'd1);
        // The first tick lands 1..4 clocks after acceptance.
        // Hence the done cycle falls 4*FRAME_TICKS-4 .. 4*FRAME_TICKS-1 clocks after it.
        off = lastDoneCyc - eCyc;
        checkOutput("doneTiming", 32'(off >= 4 * FRAME_TICKS - 4 && off <= 4 * FRAME_TICKS - 1), 32'd1);
    endtask

    initial begin
        int startDone, w, n;
        bit hold;
        logic [7:0] r;

        reset    = 1'b1;
        tx_start = 1'b0;
        din      = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle line after reset: high, not busy, never done.
        repeat (2000) @(posedge clk);
        @(negedge clk);
        checkOutput("idleTx", 32'(tx), 32'd1);
        checkOutput("idleBusy", 32'(tx_busy), 32'd0);
        checkOutput("idleDone", 32'(doneCount), 32'd0);

        // Literal frames.
        // A5 is 0,1,0,1,0,0,1,0,1,1 on the line.
        // 3C is sent with a mid-frame din change and an extra start request.
`ifdef UART_TX_PARITY_EN
        pinFrame(8'h07, 12'b0110_0000_1110, 1'b0);
        pinFrame(8'hA5, 12'b0101_0100_1010, 1'b0);
        pinFrame(8'h3C, 12'b0100_0111_1000, 1'b1);
`else
        pinFrame(8'hA5, 12'b0011_0100_1010, 1'b0);
        pinFrame(8'h3C, 12'b0010_0111_1000, 1'b1);
`endif

        // Held tx_start: one idle-high clock, then the next frame with the updated din.
        waitIdle();
        @(posedge clk);
        #1;
        din      = 8'h00;
        tx_start = 1'b1;
        w        = 0;
        while (!tx_done_tick && w < 2000) begin
            @(negedge clk);
            w++;
        end
        checkOutput("doneTimeout", 32'(w < 2000), 32'd1);
        din = 8'hFF;
        @(negedge clk);
        checkOutput("gapTx", 32'(tx), 32'd1);
        checkOutput("gapBusy", 32'(tx_busy), 32'd0);
        @(negedge clk);
        checkOutput("restartTx", 32'(tx), 32'd0);
        checkOutput("restartBusy", 32'(tx_busy), 32'd1);
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        waitIdle();

        // Reset during data bit 3: the line goes high at once and no done pulse appears.
        startDone = doneCount;
        applyStimulus(8'h5A);
        repeat (32 + 64 * 4 - (cyc - eCyc)) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rstTx", 32'(tx), 32'd1);
        checkOutput("rstBusy", 32'(tx_busy), 32'd0);
        checkOutput("rstDone", 32'(tx_done_tick), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        checkOutput("rstNoDone", 32'(doneCount - startDone), 32'd0);
`ifdef UART_TX_PARITY_EN
        pinFrame(8'h96, 12'b0101_0010_1100, 1'b0);
`else
        pinFrame(8'h96, 12'b0011_0010_1100, 1'b0);
`endif

        // Random traffic.
        // Covers back-to-back frames, ignored requests, din churn and the odd reset.
        for (int it = 0; it < 24; it++) begin
            hold = 1'($urandom_range(0, 1));
            n    = $urandom_range(100, 4 * FRAME_TICKS + 200);
            for (int c = 0; c < n; c++) begin
                @(posedge clk);
                #1;
                if ($urandom_range(0, 31) == 0) begin
                    r   = 8'($urandom);
                    din = r;
                end
                tx_start = hold ? 1'b1 : 1'($urandom_range(0, 15) == 0);
                if (it % 8 == 7 && c == n / 2) reset = 1'b1;
                if (reset && c == n / 2 + 2) reset = 1'b0;
            end
            @(posedge clk);
            #1;
            tx_start = 1'b0;
            reset    = 1'b0;
            waitIdle();
        end

        repeat (10) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
